alu_cmd_seq: RTL and testbench

Command sequencer placed directly upstream of the team's 8-bit ALU: it buffers {op, A, B} commands in a small FIFO, drives them one at a time onto the ALU's registered operand/select inputs, and waits one settle cycle. It then captures the ALU's 8-bit result and presents it on a valid/ready result port together with the opcode that produced it. Producers never touch the ALU directly; this block serialises and back-pressures all ALU traffic.

---
 rtl/alu_cmd_seq_pkg.sv | 35 +++
 rtl/alu_cmd_fifo.sv | 57 +++++
 rtl/alu_cmd_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_seq_pkg.sv
// alu_cmd_seq_pkg: shared types and constants for the ALU command sequencer.
// Holds the FSM state encoding, the ALU opcode map and the command record.

package alu_cmd_seq_pkg;

    // Datapath widths the ALU is built for
    localparam int DATA_W = 8;
    localparam int OP_W   = 3;
    localparam int TAG_W  = 4;

    // ALU select codes (the sequencer forwards these untouched)
    localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD2B = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB2B = 3'b011;
    localparam logic [OP_W-1:0] OP_ADDLO = 3'b100;
    localparam logic [OP_W-1:0] OP_MAX   = 3'b101;
    localparam logic [OP_W-1:0] OP_ABS   = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // One ALU command as offered by a producer
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding queued ALU commands.
// DEPTH must be a power of two >= 2; full/empty come from an extra wrap bit
// on each pointer. The read port is the current head (no bypass: a word
// written at one edge is visible as head only after that edge).

module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer advance; a push and pop in the same cycle both take effect
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write
    // NOTE: the array has no reset; the pointers alone define which entries
    // are valid, so clearing storage would only cost flops and reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer in front of the 8-bit ALU.
// Queues {op, A, B} commands, drives them one at a time onto registered ALU
// operand/select lines, waits one settle cycle, captures the ALU result and
// holds it on a valid/ready result port with the opcode that produced it.
// Optional feature: define ALU_CMD_SEQ_TAG_EN to carry a 4-bit tag from
// cmd_tag through the FIFO to res_tag alongside each result.

module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    // command side
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
`ifdef ALU_CMD_SEQ_TAG_EN
    input  logic [3:0]   cmd_tag,
    output logic [3:0]   res_tag,
`endif
    // ALU side
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_result,
    // result side
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [2:0]   res_op,
    output logic         busy
);

    // Plain-vector state encodings, taken from the package enum
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETTLE = ST_SETTLE;
    localparam logic [1:0] S_HOLD   = ST_HOLD;

    // FIFO entry layout: [tag] | op | a | b
    localparam int CMD_W = OP_W + 2 * W;
`ifdef ALU_CMD_SEQ_TAG_EN
    localparam int ENTRY_W = CMD_W + TAG_W;
`else
    localparam int ENTRY_W = CMD_W;
`endif

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] head;
    logic [W-1:0]       head_a;
    logic [W-1:0]       head_b;
    logic [2:0]         head_op;
`ifdef ALU_CMD_SEQ_TAG_EN
    logic [3:0]         head_tag;
    logic [3:0]         alu_tag;
`endif

    // Producer handshake; ready depends only on the registered full flag,
    // so a push while full is refused even in a cycle that also pops.
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;

`ifdef ALU_CMD_SEQ_TAG_EN
    assign wdata = {cmd_tag, cmd_op, cmd_a, cmd_b};
`else
    assign wdata = {cmd_op, cmd_a, cmd_b};
`endif

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Split the FIFO head into its fields
    assign head_b  = head[W-1:0];
    assign head_a  = head[2*W-1:W];
    assign head_op = head[CMD_W-1:2*W];
`ifdef ALU_CMD_SEQ_TAG_EN
    assign head_tag = head[ENTRY_W-1:CMD_W];
`endif

    // Pop decision and next state: a new command is issued from IDLE, or
    // straight from HOLD when the consumer takes the current result
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pop       = 1'b0;
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = S_SETTLE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ALU operand/select registers: change only on a pop, so the ALU inputs
    // never move while a result is settling or being held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (pop) begin
            alu_a   <= head_a;
            alu_b   <= head_b;
            alu_sel <= head_op;
        end
    end

`ifdef ALU_CMD_SEQ_TAG_EN
    // Tag of the command currently on the ALU, paired with its result later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   alu_tag <= '0;
        else if (pop) alu_tag <= head_tag;
    end
`endif

    // Result capture at the end of the settle cycle; valid drops on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
        end else if (state == S_SETTLE) begin
            res_valid <= 1'b1;
            res_data  <= alu_result;
            res_op    <= alu_sel;
        end else if (state == S_HOLD && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ALU_CMD_SEQ_TAG_EN
    // Tag travels with the captured result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 res_tag <= '0;
        else if (state == S_SETTLE) res_tag <= alu_tag;
    end
`endif

    assign busy = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: self-checking bench for alu_cmd_seq.
// A behavioural ALU closes the loop on alu_a/alu_b/alu_sel. Expected results
// are queued when a command is accepted and compared when a result is taken.

module tb_alu_cmd_seq;
    import alu_cmd_seq_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_result;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [2:0]   res_op;
    logic         busy;
`ifdef ALU_CMD_SEQ_TAG_EN
    logic [3:0]   cmd_tag;
    logic [3:0]   res_tag;
`endif

    alu_cmd_seq #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
`ifdef ALU_CMD_SEQ_TAG_EN
        .cmd_tag    (cmd_tag),
        .res_tag    (res_tag),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    function automatic logic [7:0] alu_model(input logic [2:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_ADD2B: return a + {b[6:0], 1'b0};
            OP_SUB2B: return a - {b[6:0], 1'b0};
            OP_ADDLO: return a + {4'h0, b[3:0]};
            OP_MAX:   return (a > b) ? a : b;
            OP_ABS:   return a[7] ? (8'h00 - a) : a;
            default:  return b;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_sel, alu_a, alu_b);

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [3:0] tag;
    } exp_t;

    typedef struct {
        cmd_t       cmd;
        logic [3:0] tag;
        logic [7:0] exp;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   res_count = 0;
    int   res_cyc_last = 0;
    int   res_cyc_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: a result is taken when valid && ready before an edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0h op %0h, expected none",
                         res_data, res_op);
            end else begin
                e = sb.pop_front();
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_op", 32'(res_op), 32'(e.op));
`ifdef ALU_CMD_SEQ_TAG_EN
                check("res_tag", 32'(res_tag), 32'(e.tag));
`endif
            end
            res_count++;
            res_cyc_prev = res_cyc_last;
            res_cyc_last = cyc;
        end
    end

    // Offer one command (called just after a rising edge); queue its
    // expectation once accepted and return just after the accepting edge
    task automatic send(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] tag,
                        input logic [7:0] exp);
        int n;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
`ifdef ALU_CMD_SEQ_TAG_EN
        cmd_tag   = tag;
`endif
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            e.op   = op;
            e.data = exp;
            e.tag  = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait until every expected result was taken and the block is idle
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, 32'(sb.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_res_valid();
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_res_valid", 32'(res_valid), 32'd1);
    endtask

    vec_t vecs [11];
    int   base;

    initial begin
        // Table of {op, a, b}, tag, expected result
        vecs[0]  = '{'{OP_ADD,   8'h05, 8'h03}, 4'h1, 8'h08};
        vecs[1]  = '{'{OP_ADD,   8'hFF, 8'h01}, 4'h2, 8'h00};
        vecs[2]  = '{'{OP_SUB,   8'h0A, 8'h03}, 4'h3, 8'h07};
        vecs[3]  = '{'{OP_SUB,   8'h00, 8'h01}, 4'h4, 8'hFF};
        vecs[4]  = '{'{OP_ADD2B, 8'h10, 8'h20}, 4'h5, 8'h50};
        vecs[5]  = '{'{OP_SUB2B, 8'h50, 8'h10}, 4'h6, 8'h30};
        vecs[6]  = '{'{OP_ADDLO, 8'h12, 8'h3F}, 4'h7, 8'h21};
        vecs[7]  = '{'{OP_MAX,   8'h7F, 8'h80}, 4'h8, 8'h80};
        vecs[8]  = '{'{OP_ABS,   8'hF6, 8'h00}, 4'h9, 8'h0A};
        vecs[9]  = '{'{OP_ABS,   8'h80, 8'h55}, 4'hA, 8'h80};
        vecs[10] = '{'{OP_PASSB, 8'h12, 8'hAA}, 4'hB, 8'hAA};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b0;
`ifdef ALU_CMD_SEQ_TAG_EN
        cmd_tag   = '0;
`endif

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_op", 32'(res_op), 32'd0);
`ifdef ALU_CMD_SEQ_TAG_EN
        check("rst_res_tag", 32'(res_tag), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- single command latency: push at k, load at k+1, valid after k+2 ----
        send(OP_ADD, 8'h05, 8'h03, 4'h0, 8'h08);
        @(negedge clk);
        check("lat_k_res_valid", 32'(res_valid), 32'd0);
        check("lat_k_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_k1_res_valid", 32'(res_valid), 32'd0);
        check("lat_k1_alu_a", 32'(alu_a), 32'h05);
        check("lat_k1_alu_b", 32'(alu_b), 32'h03);
        check("lat_k1_alu_sel", 32'(alu_sel), 32'(OP_ADD));
        @(negedge clk);
        check("lat_k2_res_valid", 32'(res_valid), 32'd1);
        check("lat_k2_res_data", 32'(res_data), 32'h08);
        repeat (2) @(negedge clk);
        check("hold_res_valid", 32'(res_valid), 32'd1);
        check("hold_res_data", 32'(res_data), 32'h08);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_drain("single");
        check("single_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;

        // ---- fill: one command on the ALU plus DEPTH queued, then refuse ----
        res_ready = 1'b0;
        base = res_count;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(3'(i), 8'(8'h11 * (i + 1)), 8'(i + 2), 4'(i),
                 alu_model(3'(i), 8'(8'h11 * (i + 1)), 8'(i + 2)));
            if (i == DEPTH - 1) check("fill_ready_not_full", 32'(cmd_ready), 32'd1);
        end
        check("fill_ready_full", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = OP_PASSB;
        cmd_a     = 8'h00;
        cmd_b     = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_refuse_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("full_res_data", 32'(res_data), 32'(alu_model(3'd0, 8'h11, 8'h02)));
        res_ready = 1'b1;
        wait_drain("fill");
        check("fill_count", 32'(res_count - base), 32'(DEPTH + 1));
        @(posedge clk);
        #1;

        // ---- throughput with res_ready held high ----
        base = res_count;
        send(OP_SUB, 8'd10, 8'd3, 4'h1, 8'h07);
        send(OP_PASSB, 8'h5C, 8'hAA, 4'h2, 8'hAA);
        wait_drain("thru");
        check("thru_count", 32'(res_count - base), 32'd2);
        check("thru_spacing", 32'(res_cyc_last - res_cyc_prev), 32'd2);
        @(posedge clk);
        #1;

        // ---- simultaneous push and pop at occupancy 2 ----
        res_ready = 1'b0;
        send(OP_ADD, 8'h01, 8'h01, 4'h1, 8'h02);
        send(OP_ADD, 8'h02, 8'h02, 4'h2, 8'h04);
        send(OP_ADD, 8'h03, 8'h03, 4'h3, 8'h06);
        wait_res_valid();
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(OP_ADD, 8'h04, 8'h04, 4'h4, 8'h08);
        res_ready = 1'b0;
        send(OP_ADD, 8'h05, 8'h05, 4'h5, 8'h0A);
        check("pp_ready_occ3", 32'(cmd_ready), 32'd1);
        send(OP_ADD, 8'h06, 8'h06, 4'h6, 8'h0C);
        check("pp_ready_occ4", 32'(cmd_ready), 32'd0);
        res_ready = 1'b1;
        wait_drain("pushpop");
        @(posedge clk);
        #1;

        // ---- reset while holding a result with three queued ----
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(OP_SUB, 8'h40, 8'(i), 4'(i), 8'(8'h40 - i));
        wait_res_valid();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_res_data", 32'(res_data), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        base = res_count;
        repeat (8) @(negedge clk);
        check("post_rst_no_result", 32'(res_count - base), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // ---- table of vectors, every opcode, back to back ----
        base = res_count;
        for (int i = 0; i < 11; i++)
            send(vecs[i].cmd.op, vecs[i].cmd.a, vecs[i].cmd.b, vecs[i].tag, vecs[i].exp);
        wait_drain("table");
        check("table_count", 32'(res_count - base), 32'd11);
        @(posedge clk);
        #1;

        // ---- tags returned with their results ----
        res_ready = 1'b0;
        send(OP_ADD, 8'h20, 8'h01, 4'h3, 8'h21);
        send(OP_SUB, 8'h20, 8'h01, 4'hC, 8'h1F);
        wait_res_valid();
`ifdef ALU_CMD_SEQ_TAG_EN
        check("tag_first_held", 32'(res_tag), 32'h3);
`endif
        res_ready = 1'b1;
        wait_drain("tag");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
